mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-ported unified memory between instruction fetch (IF) and data access (MEM).
//  Sequences each access with a req/ack handshake and tolerates variable memory latency.
//  Generates if_stall_o / mem_stall_o, which feed the hazard unit's PC, IF/ID and EX/MEM stall logic.
//  Data has priority over fetch; a starvation counter guarantees fetch progress.
//  A branch/jump flush abandons an in-flight fetch.
// PARAMETERS
//  XLEN          32  data width (bits) of rdata/wdata
//  ADDR_W        32  address width
//  STARVE_LIMIT  4   max consecutive data grants while a fetch waits; 1..15
// PORTS
//  clk_i         in   1       clock, all state on rising edge
//  rst_i         in   1       synchronous active-high reset
//  flush_i       in   1       branch/jump redirect; fetch in flight is discarded
//  if_req_i      in   1       fetch request; held with if_addr_i stable until if_ack_o
//  if_addr_i     in   ADDR_W  fetch address
//  if_ack_o      out  1       1-cycle pulse; if_rdata_o valid this cycle
//  if_rdata_o    out  XLEN    instruction word (m_rdata_i pass-through)
//  d_req_i       in   1       data request; held with d_* stable until d_ack_o
//  d_we_i        in   1       1 = store, 0 = load
//  d_addr_i      in   ADDR_W  data address
//  d_wdata_i     in   XLEN    store data
//  d_be_i        in   XLEN/8  byte enables
//  d_ack_o       out  1       1-cycle pulse; load data valid / store done
//  d_rdata_o     out  XLEN    load data (m_rdata_i pass-through)
//  m_req_o       out  1       memory request, registered; held until m_ack_i
//  m_we_o, m_addr_o, m_wdata_o, m_be_o  out  1/ADDR_W/XLEN/XLEN/8  registered at grant
//  m_ack_i       in   1       memory done pulse; m_rdata_i valid same cycle
//  m_rdata_i     in   XLEN    memory read data
//  if_stall_o    out  1       = if_req_i & ~if_ack_o
//  mem_stall_o   out  1       = d_req_i & ~d_ack_o
// BEHAVIOUR
//  Reset: state=IDLE; m_req_o, m_we_o, if_ack_o, d_ack_o = 0; m_addr_o, m_wdata_o, m_be_o = 0.
//  Reset also clears the starve counter (scnt) and drop flag; a reset mid-access abandons it.
//  FSM states: IDLE, FETCH, DATA.
//  IDLE, grant decision:
//   - d_req_i & ~(if_req_i & scnt==STARVE_LIMIT): go to DATA.
//   - else if_req_i & ~flush_i: go to FETCH.
//  On grant edge: latch m_* from the granted requester and set m_req_o=1.
//  FETCH/DATA: hold m_req_o and m_* until m_ack_i=1, then return to IDLE.
//  On return to IDLE: m_req_o=0.
//  Completion acks, combinational on m_ack_i:
//   - if_ack_o = (state==FETCH) & m_ack_i & ~drop.
//   - d_ack_o  = (state==DATA)  & m_ack_i.
//  Latency: request seen at edge k -> m_req_o high from k+1 -> ack in the cycle of m_ack_i.
//  Minimum 2 cycles per access (IDLE between accesses; no back-to-back grant).
//  flush_i:
//   - In FETCH it sets drop; the pending access still completes on the memory side, but no if_ack_o.
//   - drop clears on return to IDLE.
//   - In IDLE it blocks a fetch grant that cycle only.
//   - Never affects data.
//  Starve counter (scnt):
//   - +1 on each data grant made while if_req_i=1; saturates at STARVE_LIMIT.
//   - Cleared on fetch grant, or when if_req_i=0 in IDLE.
//  m_ack_i in IDLE is ignored (stale ack after reset).
//  Simultaneous flush_i and m_ack_i in FETCH: ack suppressed.
//  Requester rules: req deasserted before ack is illegal, except IF under flush_i.
// TESTING
//  1 Lone fetch: if_req_i=1, addr 0x100, m_ack_i 3 cycles after m_req_o
//    -> m_addr_o=0x100; one if_ack_o pulse; if_stall_o=1 for 4 cycles.
//  2 Both req in IDLE, scnt=0 -> DATA granted first, fetch next.
//    mem_stall_o drops before if_stall_o.
//  3 Continuous d_req_i with if_req_i, STARVE_LIMIT=4
//    -> grants D,D,D,D,F,D...; scnt returns to 0 after the F grant.
//  4 flush_i pulse mid-FETCH, m_ack_i 2 cycles later -> no if_ack_o; state IDLE.
//    A new fetch to 0x200 is then granted and acked.
//  5 Store d_we_i=1, be=0x3, wdata 0xDEADBEEF
//    -> m_we_o=1, m_be_o=0x3, m_wdata_o=0xDEADBEEF until m_ack_i; one d_ack_o.
//  6 rst_i asserted mid-DATA -> next cycle m_req_o=0, state IDLE.
//    A late m_ack_i produces no ack.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbiter that lets instruction fetch and data access share one single-ported
// unified memory. Data wins over fetch, with a starvation counter that forces a
// fetch grant after STARVE_LIMIT consecutive data grants taken while a fetch
// was waiting. A branch/jump flush abandons an in-flight fetch: the memory
// still completes it, but the result is never acknowledged to IF.
//
// Handshakes: a requester raises *_req and holds it, with its address/data
// stable, until the matching *_ack pulses for one cycle. The only exception is
// IF, which may drop if_req_i together with flush_i. On the memory side,
// m_req_o and m_* stay registered and stable until m_ack_i is seen, and
// m_rdata_i is valid in the m_ack_i cycle.
module mem_port_arbiter #(
  parameter int XLEN         = 32,
  parameter int ADDR_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                flush_i,
  input  logic                if_req_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  output logic                if_ack_o,
  output logic [XLEN-1:0]     if_rdata_o,
  input  logic                d_req_i,
  input  logic                d_we_i,
  input  logic [ADDR_W-1:0]   d_addr_i,
  input  logic [XLEN-1:0]     d_wdata_i,
  input  logic [XLEN/8-1:0]   d_be_i,
  output logic                d_ack_o,
  output logic [XLEN-1:0]     d_rdata_o,
  output logic                m_req_o,
  output logic                m_we_o,
  output logic [ADDR_W-1:0]   m_addr_o,
  output logic [XLEN-1:0]     m_wdata_o,
  output logic [XLEN/8-1:0]   m_be_o,
  input  logic                m_ack_i,
  input  logic [XLEN-1:0]     m_rdata_i,
  output logic                if_stall_o,
  output logic                mem_stall_o,
  output logic [1:0]          dbg_state_o,
  output logic [3:0]          dbg_scnt_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2
  } state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t     state;
  logic [3:0] scnt;
  logic       drop;
  logic       data_win;

  // Data wins unless a fetch has been waiting through LIMIT data grants.
  assign data_win = d_req_i && !(if_req_i && (scnt == LIMIT));

  // Grant sequencing, memory-side request registers and starvation tracking.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      m_req_o   <= 1'b0;
      m_we_o    <= 1'b0;
      m_addr_o  <= '0;
      m_wdata_o <= '0;
      m_be_o    <= '0;
      scnt      <= '0;
      drop      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          // With no fetch waiting there is nothing to count as starvation.
          if (!if_req_i) scnt <= '0;
          if (data_win) begin
            state     <= DATA;
            m_req_o   <= 1'b1;
            m_we_o    <= d_we_i;
            m_addr_o  <= d_addr_i;
            m_wdata_o <= d_wdata_i;
            m_be_o    <= d_be_i;
            if (if_req_i && (scnt != LIMIT)) scnt <= scnt + 4'd1;
          end else if (if_req_i && !flush_i) begin
            // A fetch is a full-word read; no write data travels with it.
            state     <= FETCH;
            m_req_o   <= 1'b1;
            m_we_o    <= 1'b0;
            m_addr_o  <= if_addr_i;
            m_wdata_o <= '0;
            m_be_o    <= '1;
            scnt      <= '0;
          end
        end
        FETCH: begin
          if (flush_i) drop <= 1'b1;
          if (m_ack_i) begin
            state   <= IDLE;
            m_req_o <= 1'b0;
            drop    <= 1'b0;
          end
        end
        DATA: begin
          if (m_ack_i) begin
            state   <= IDLE;
            m_req_o <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          m_req_o <= 1'b0;
        end
      endcase
    end
  end

  // A flush arriving in the same cycle as the memory ack also kills the fetch.
  assign if_ack_o    = (state == FETCH) && m_ack_i && !drop && !flush_i;
  assign d_ack_o     = (state == DATA) && m_ack_i;
  assign if_rdata_o  = m_rdata_i;
  assign d_rdata_o   = m_rdata_i;
  assign if_stall_o  = if_req_i && !if_ack_o;
  assign mem_stall_o = d_req_i && !d_ack_o;
  assign dbg_state_o = state;
  assign dbg_scnt_o  = scnt;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a per-cycle vector table for single
// accesses, then hand-written sequences for starvation, flush and reset.
module tb_mem_port_arbiter;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;

  logic        clk = 1'b0;
  logic        rst_i, flush_i, if_req_i, d_req_i, d_we_i, m_ack_i;
  logic [31:0] if_addr_i, d_addr_i, d_wdata_i, m_rdata_i;
  logic [3:0]  d_be_i;
  logic        if_ack_o, d_ack_o, m_req_o, m_we_o, if_stall_o, mem_stall_o;
  logic [31:0] if_rdata_o, d_rdata_o, m_addr_o, m_wdata_o;
  logic [3:0]  m_be_o, dbg_scnt_o;
  logic [1:0]  dbg_state_o;

  int total = 0;
  int bad   = 0;

  mem_port_arbiter #(.XLEN(32), .ADDR_W(32), .STARVE_LIMIT(4)) dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_ack_o(if_ack_o), .if_rdata_o(if_rdata_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
    .d_be_i(d_be_i), .d_ack_o(d_ack_o), .d_rdata_o(d_rdata_o),
    .m_req_o(m_req_o), .m_we_o(m_we_o), .m_addr_o(m_addr_o), .m_wdata_o(m_wdata_o),
    .m_be_o(m_be_o), .m_ack_i(m_ack_i), .m_rdata_i(m_rdata_i),
    .if_stall_o(if_stall_o), .mem_stall_o(mem_stall_o),
    .dbg_state_o(dbg_state_o), .dbg_scnt_o(dbg_scnt_o)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        rst, flush, if_req;
    logic [31:0] if_addr;
    logic        d_req, d_we;
    logic [31:0] d_addr, d_wdata;
    logic [3:0]  d_be;
    logic        m_ack;
    logic [31:0] m_rdata;
    logic [1:0]  e_state;
    logic [3:0]  e_scnt;
    logic        e_m_req, e_m_we;
    logic [31:0] e_m_addr, e_m_wdata;
    logic [3:0]  e_m_be;
    logic        e_if_ack, e_d_ack, e_if_stall, e_mem_stall;
  } vec_t;

  vec_t cur;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic in_v(input logic rst, input logic flush, input logic if_req,
                      input logic [31:0] if_addr, input logic d_req, input logic d_we,
                      input logic [31:0] d_addr, input logic [31:0] d_wdata,
                      input logic [3:0] d_be, input logic m_ack, input logic [31:0] m_rdata);
    cur.rst = rst; cur.flush = flush; cur.if_req = if_req; cur.if_addr = if_addr;
    cur.d_req = d_req; cur.d_we = d_we; cur.d_addr = d_addr; cur.d_wdata = d_wdata;
    cur.d_be = d_be; cur.m_ack = m_ack; cur.m_rdata = m_rdata;
  endtask

  task automatic ex(input logic [1:0] st, input logic [3:0] sc, input logic mreq,
                    input logic mwe, input logic [31:0] maddr, input logic [31:0] mwdata,
                    input logic [3:0] mbe, input logic ifack, input logic dack,
                    input logic ifst, input logic mst);
    cur.e_state = st; cur.e_scnt = sc; cur.e_m_req = mreq; cur.e_m_we = mwe;
    cur.e_m_addr = maddr; cur.e_m_wdata = mwdata; cur.e_m_be = mbe;
    cur.e_if_ack = ifack; cur.e_d_ack = dack; cur.e_if_stall = ifst; cur.e_mem_stall = mst;
    tbl.push_back(cur);
  endtask

  // Driver tasks
  task automatic drive_zero();
    rst_i = 1'b0; flush_i = 1'b0; if_req_i = 1'b0; if_addr_i = '0;
    d_req_i = 1'b0; d_we_i = 1'b0; d_addr_i = '0; d_wdata_i = '0; d_be_i = '0;
    m_ack_i = 1'b0; m_rdata_i = '0;
  endtask

  task automatic apply(input vec_t v);
    rst_i = v.rst; flush_i = v.flush; if_req_i = v.if_req; if_addr_i = v.if_addr;
    d_req_i = v.d_req; d_we_i = v.d_we; d_addr_i = v.d_addr; d_wdata_i = v.d_wdata;
    d_be_i = v.d_be; m_ack_i = v.m_ack; m_rdata_i = v.m_rdata;
  endtask

  // Called at a falling edge with inputs already driven; returns at negedge+1
  // once m_req_o is high, or flags a timeout.
  task automatic wait_busy(input string name);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (m_req_o === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk({name, "_grant_seen"}, 32'(seen), 32'd1);
  endtask

  logic [1:0] exp_q[$];
  logic [3:0] exp_scnt_q[$];
  logic [1:0] exp_st;
  logic [3:0] exp_sc;

  initial begin
    drive_zero();
    rst_i = 1'b1;
    repeat (2) @(posedge clk);

    // cyc 0: reset state
    in_v(1,0,0,32'h0,0,0,32'h0,32'h0,4'h0,0,32'h0);
    ex(S_IDLE,0,0,0,32'h0,32'h0,4'h0,0,0,0,0);
    // cyc 1-6: lone fetch of 0x100, memory acks 3 cycles after m_req_o rises
    in_v(0,0,1,32'h100,0,0,32'h0,32'h0,4'h0,0,32'h0);
    ex(S_IDLE,0,0,0,32'h0,32'h0,4'h0,0,0,1,0);
    for (int i = 0; i < 3; i++) begin
      in_v(0,0,1,32'h100,0,0,32'h0,32'h0,4'h0,0,32'h0);
      ex(S_FETCH,0,1,0,32'h100,32'h0,4'hF,0,0,1,0);
    end
    in_v(0,0,1,32'h100,0,0,32'h0,32'h0,4'h0,1,32'h13);
    ex(S_FETCH,0,1,0,32'h100,32'h0,4'hF,1,0,0,0);
    in_v(0,0,0,32'h0,0,0,32'h0,32'h0,4'h0,0,32'h0);
    ex(S_IDLE,0,0,0,32'h100,32'h0,4'hF,0,0,0,0);
    // cyc 7-10: store 0xDEADBEEF, be=0x3 to 0x40
    in_v(0,0,0,32'h0,1,1,32'h40,32'hDEADBEEF,4'h3,0,32'h0);
    ex(S_IDLE,0,0,0,32'h100,32'h0,4'hF,0,0,0,1);
    in_v(0,0,0,32'h0,1,1,32'h40,32'hDEADBEEF,4'h3,0,32'h0);
    ex(S_DATA,0,1,1,32'h40,32'hDEADBEEF,4'h3,0,0,0,1);
    in_v(0,0,0,32'h0,1,1,32'h40,32'hDEADBEEF,4'h3,1,32'h0);
    ex(S_DATA,0,1,1,32'h40,32'hDEADBEEF,4'h3,0,1,0,0);
    in_v(0,0,0,32'h0,0,0,32'h0,32'h0,4'h0,0,32'h0);
    ex(S_IDLE,0,0,1,32'h40,32'hDEADBEEF,4'h3,0,0,0,0);
    // cyc 11-17: fetch and load together; data first, then fetch
    in_v(0,0,1,32'h104,1,0,32'h80,32'h0,4'hF,0,32'h0);
    ex(S_IDLE,0,0,1,32'h40,32'hDEADBEEF,4'h3,0,0,1,1);
    in_v(0,0,1,32'h104,1,0,32'h80,32'h0,4'hF,0,32'h0);
    ex(S_DATA,1,1,0,32'h80,32'h0,4'hF,0,0,1,1);
    in_v(0,0,1,32'h104,1,0,32'h80,32'h0,4'hF,1,32'hCAFE);
    ex(S_DATA,1,1,0,32'h80,32'h0,4'hF,0,1,1,0);
    in_v(0,0,1,32'h104,0,0,32'h0,32'h0,4'h0,0,32'h0);
    ex(S_IDLE,1,0,0,32'h80,32'h0,4'hF,0,0,1,0);
    in_v(0,0,1,32'h104,0,0,32'h0,32'h0,4'h0,0,32'h0);
    ex(S_FETCH,0,1,0,32'h104,32'h0,4'hF,0,0,1,0);
    in_v(0,0,1,32'h104,0,0,32'h0,32'h0,4'h0,1,32'h00000013);
    ex(S_FETCH,0,1,0,32'h104,32'h0,4'hF,1,0,0,0);
    in_v(0,0,0,32'h0,0,0,32'h0,32'h0,4'h0,0,32'h0);
    ex(S_IDLE,0,0,0,32'h104,32'h0,4'hF,0,0,0,0);

    foreach (tbl[i]) begin
      @(negedge clk);
      apply(tbl[i]);
      #1;
      chk($sformatf("v%0d_state", i), 32'(dbg_state_o), 32'(tbl[i].e_state));
      chk($sformatf("v%0d_scnt", i), 32'(dbg_scnt_o), 32'(tbl[i].e_scnt));
      chk($sformatf("v%0d_m_req", i), 32'(m_req_o), 32'(tbl[i].e_m_req));
      chk($sformatf("v%0d_m_we", i), 32'(m_we_o), 32'(tbl[i].e_m_we));
      chk($sformatf("v%0d_m_addr", i), m_addr_o, tbl[i].e_m_addr);
      chk($sformatf("v%0d_m_wdata", i), m_wdata_o, tbl[i].e_m_wdata);
      chk($sformatf("v%0d_m_be", i), 32'(m_be_o), 32'(tbl[i].e_m_be));
      chk($sformatf("v%0d_if_ack", i), 32'(if_ack_o), 32'(tbl[i].e_if_ack));
      chk($sformatf("v%0d_d_ack", i), 32'(d_ack_o), 32'(tbl[i].e_d_ack));
      chk($sformatf("v%0d_if_stall", i), 32'(if_stall_o), 32'(tbl[i].e_if_stall));
      chk($sformatf("v%0d_mem_stall", i), 32'(mem_stall_o), 32'(tbl[i].e_mem_stall));
      if (tbl[i].e_if_ack) chk($sformatf("v%0d_if_rdata", i), if_rdata_o, tbl[i].m_rdata);
      if (tbl[i].e_d_ack)  chk($sformatf("v%0d_d_rdata", i), d_rdata_o, tbl[i].m_rdata);
    end

    // Starvation: continuous data plus waiting fetch -> D,D,D,D,F,D
    exp_q      = '{S_DATA, S_DATA, S_DATA, S_DATA, S_FETCH, S_DATA};
    exp_scnt_q = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd0, 4'd1};
    @(negedge clk);
    drive_zero();
    if_req_i = 1'b1; if_addr_i = 32'h300;
    d_req_i = 1'b1; d_addr_i = 32'h500; d_be_i = 4'hF;
    for (int g = 0; g < 6; g++) begin
      wait_busy($sformatf("starve%0d", g));
      exp_st = exp_q.pop_front();
      exp_sc = exp_scnt_q.pop_front();
      chk($sformatf("starve%0d_kind", g), 32'(dbg_state_o), 32'(exp_st));
      chk($sformatf("starve%0d_scnt", g), 32'(dbg_scnt_o), 32'(exp_sc));
      m_ack_i = 1'b1; m_rdata_i = 32'(g);
      #1;
      if (exp_st == S_FETCH) chk($sformatf("starve%0d_if_ack", g), 32'(if_ack_o), 32'd1);
      else                   chk($sformatf("starve%0d_d_ack", g), 32'(d_ack_o), 32'd1);
      @(negedge clk);
      m_ack_i = 1'b0;
    end
    drive_zero();

    // Flush mid-FETCH: access completes on memory side, no if_ack_o
    @(negedge clk);
    if_req_i = 1'b1; if_addr_i = 32'h180;
    wait_busy("flush");
    chk("flush_in_fetch", 32'(dbg_state_o), 32'(S_FETCH));
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0; if_req_i = 1'b0;
    @(negedge clk);
    m_ack_i = 1'b1; m_rdata_i = 32'h11111111;
    #1;
    chk("flush_no_if_ack", 32'(if_ack_o), 32'd0);
    @(negedge clk);
    m_ack_i = 1'b0;
    #1;
    chk("flush_back_idle", 32'(dbg_state_o), 32'(S_IDLE));

    // Flush in IDLE blocks that cycle's fetch grant only; then fetch 0x200
    if_req_i = 1'b1; if_addr_i = 32'h200; flush_i = 1'b1;
    @(negedge clk);
    #1;
    chk("idle_flush_block", 32'(dbg_state_o), 32'(S_IDLE));
    flush_i = 1'b0;
    @(negedge clk);
    wait_busy("refetch");
    chk("refetch_state", 32'(dbg_state_o), 32'(S_FETCH));
    chk("refetch_addr", m_addr_o, 32'h200);
    m_ack_i = 1'b1; m_rdata_i = 32'h00200013;
    #1;
    chk("refetch_if_ack", 32'(if_ack_o), 32'd1);
    chk("refetch_rdata", if_rdata_o, 32'h00200013);
    @(negedge clk);
    m_ack_i = 1'b0; if_req_i = 1'b0;

    // Flush coinciding with m_ack_i in FETCH suppresses the ack
    @(negedge clk);
    if_req_i = 1'b1; if_addr_i = 32'h204;
    wait_busy("flush_ack");
    m_ack_i = 1'b1; flush_i = 1'b1;
    #1;
    chk("flush_same_cycle_ack", 32'(if_ack_o), 32'd0);
    @(negedge clk);
    m_ack_i = 1'b0; flush_i = 1'b0; if_req_i = 1'b0;
    #1;
    chk("flush_same_cycle_idle", 32'(dbg_state_o), 32'(S_IDLE));

    // Reset mid-DATA, then a late memory ack must be ignored
    @(negedge clk);
    d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h600; d_be_i = 4'hF;
    wait_busy("rst");
    chk("rst_in_data", 32'(dbg_state_o), 32'(S_DATA));
    rst_i = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_m_req", 32'(m_req_o), 32'd0);
    chk("rst_state", 32'(dbg_state_o), 32'(S_IDLE));
    chk("rst_m_addr", m_addr_o, 32'h0);
    rst_i = 1'b0; d_req_i = 1'b0; m_ack_i = 1'b1;
    #1;
    chk("late_ack_d", 32'(d_ack_o), 32'd0);
    chk("late_ack_if", 32'(if_ack_o), 32'd0);
    @(negedge clk);
    m_ack_i = 1'b0;
    #1;
    chk("late_ack_state", 32'(dbg_state_o), 32'(S_IDLE));
    chk("late_ack_m_req", 32'(m_req_o), 32'd0);

    // Final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
